// File: rtl/apb_arb_master.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : apb_arb_master                                                 |
// | Purpose  : Round-robin arbiter of NUM_REQ request ports onto one APB bus  |
// |            with one-hot psel decode; optional ACCESS timeout enabled by   |
// |            the macro APB_ARB_MASTER_TIMEOUT_EN.                           |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module apb_arb_master #(
  parameter int NUM_REQ        = 4,
  parameter int PADDR_WIDTH    = 32,
  parameter int PWDATA_WIDTH   = 32,
  parameter int PRDATA_WIDTH   = 32,
  parameter int NUM_SLAVES     = 16,
  parameter int SLAVE_ADDR_LSB = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              pclock,
  input  logic                              preset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*PADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*PWDATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [PRDATA_WIDTH-1:0]           rsp_rdata,
  output logic                              rsp_err,
  output logic [PADDR_WIDTH-1:0]            paddr,
  output logic                              prwd,
  output logic [PWDATA_WIDTH-1:0]           pwdata,
  output logic                              penable,
  output logic [15:0]                       psel,
  input  logic [PRDATA_WIDTH-1:0]           prdata,
  input  logic                              pslverr,
  input  logic                              pready
);

  localparam int              c_gw         = $clog2(NUM_REQ);
  localparam logic [c_gw:0]   c_num_req    = (c_gw+1)'(NUM_REQ);
  localparam logic [4:0]      c_num_slaves = 5'(NUM_SLAVES);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_setup  = 2'd1;
  localparam logic [1:0] c_access = 2'd2;
  localparam logic [1:0] c_decerr = 2'd3;

  logic [1:0]              r_state, w_state_nxt;
  logic [c_gw-1:0]         r_last, r_gnt, w_grant;
  logic [c_gw:0]           w_cand;
  logic                    w_any;
  logic [3:0]              r_sidx, w_sidx;
  logic                    w_decerr, w_done, w_timeout;
  logic [PADDR_WIDTH-1:0]  r_paddr;
  logic                    r_prwd;
  logic [PWDATA_WIDTH-1:0] r_pwdata;
  logic                    r_rsp_fire, r_rsp_err;
  logic [PRDATA_WIDTH-1:0] r_rsp_rdata;

  logic [PADDR_WIDTH-1:0]  w_addr_arr  [NUM_REQ];
  logic [PWDATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = req_addr[gi*PADDR_WIDTH +: PADDR_WIDTH];
    assign w_wdata_arr[gi] = req_wdata[gi*PWDATA_WIDTH +: PWDATA_WIDTH];
  end

  // Search starts just after the last grant and wraps modulo NUM_REQ.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_last} + (c_gw+1)'(k + 1);
      if (w_cand >= c_num_req) w_cand = w_cand - c_num_req;
      if (!w_any && req_valid[w_cand[c_gw-1:0]]) begin
        w_any   = 1'b1;
        w_grant = w_cand[c_gw-1:0];
      end
    end
  end

  assign w_sidx   = w_addr_arr[w_grant][SLAVE_ADDR_LSB +: 4];
  assign w_decerr = ({1'b0, w_sidx} >= c_num_slaves);
  assign w_done   = (r_state == c_access) && pready;

`ifdef APB_ARB_MASTER_TIMEOUT_EN
  localparam int              c_tw   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_tw-1:0] c_tlim = c_tw'(TIMEOUT_CYCLES - 1);
  logic [c_tw-1:0] r_tcnt;

  assign w_timeout = (r_state == c_access) && !pready && (r_tcnt == c_tlim);

  always_ff @(posedge pclock or negedge preset) begin
    if (!preset)
      r_tcnt <= '0;
    else if ((r_state == c_access) && !pready && !w_timeout)
      r_tcnt <= r_tcnt + c_tw'(1);
    else
      r_tcnt <= '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) r_state <= c_idle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:   if (w_any) w_state_nxt = w_decerr ? c_decerr : c_setup;
      c_setup:  w_state_nxt = c_access;
      c_access: if (w_done || w_timeout) w_state_nxt = c_idle;
      c_decerr: w_state_nxt = c_idle;
      default:  w_state_nxt = c_idle;
    endcase
  end

  // req_ready is forced low while reset is held so every output is 0 in reset.
  always_comb begin
    req_ready = '0;
    psel      = '0;
    penable   = 1'b0;
    rsp_valid = '0;
    if ((r_state == c_idle) && w_any && preset) req_ready[w_grant] = 1'b1;
    if ((r_state == c_setup) || (r_state == c_access)) psel[r_sidx] = 1'b1;
    penable = (r_state == c_access);
    if (r_rsp_fire) rsp_valid[r_gnt] = 1'b1;
  end

  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      r_last      <= c_gw'(NUM_REQ - 1);
      r_gnt       <= '0;
      r_sidx      <= '0;
      r_paddr     <= '0;
      r_prwd      <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_fire  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_fire <= 1'b0;
      if ((r_state == c_idle) && w_any) begin
        r_gnt    <= w_grant;
        r_last   <= w_grant;
        r_paddr  <= w_addr_arr[w_grant];
        r_prwd   <= req_write[w_grant];
        r_pwdata <= req_write[w_grant] ? w_wdata_arr[w_grant] : '0;
        r_sidx   <= w_sidx;
        if (w_decerr) begin
          r_rsp_fire  <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= '0;
        end
      end
      if (w_done) begin
        r_rsp_fire  <= 1'b1;
        r_rsp_err   <= pslverr;
        r_rsp_rdata <= r_prwd ? '0 : prdata;
      end
      if (w_timeout) begin
        r_rsp_fire  <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign paddr     = r_paddr;
  assign prwd      = r_prwd;
  assign pwdata    = r_pwdata;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_arb_master.sv
`default_nettype none
// Bench for apb_arb_master: transaction-level model checked every cycle plus directed scenarios.
module tb_apb_arb_master;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NSL  = 8;
  localparam int TO   = 16;
`ifdef APB_ARB_MASTER_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NREQ-1:0]    req_valid = '0, req_write = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]      rsp_rdata, pwdata;
  logic               rsp_err, prwd, penable, pslverr, pready;
  logic [AW-1:0]      paddr;
  logic [15:0]        psel;
  logic [DW-1:0]      prdata = '0;
  logic               slv_err = 1'b0, stuck = 1'b0;
  int                 wait_states = 0, acc_cnt = 0, cyc = 0;
  int                 n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  apb_arb_master #(
    .NUM_REQ(NREQ), .PADDR_WIDTH(AW), .PWDATA_WIDTH(DW), .PRDATA_WIDTH(DW),
    .NUM_SLAVES(NSL), .SLAVE_ADDR_LSB(12), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclock(clk), .preset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .prwd(prwd), .pwdata(pwdata), .penable(penable), .psel(psel),
    .prdata(prdata), .pslverr(pslverr), .pready(pready)
  );

  // Slave responder: pready after wait_states ACCESS cycles unless stuck.
  assign pslverr = slv_err;
  assign pready  = penable && (acc_cnt == wait_states) && !stuck;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 acc_cnt <= 0;
    else if (penable && !pready) acc_cnt <= acc_cnt + 1;
    else                        acc_cnt <= 0;
  end
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pick(input int last, input logic [NREQ-1:0] v);
    int c;
    for (int k = 1; k <= NREQ; k++) begin
      c = (last + k) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one transfer in flight, tracked by cycles since its acceptance.
  bit            m_busy = 0, m_dec = 0, m_prwd = 0, m_rsp = 0, m_rsp_err = 0;
  int            m_age = 0, m_req = 0, m_last = NREQ - 1, m_slave = 0, m_rsp_req = 0;
  logic [AW-1:0] m_paddr = '0;
  logic [DW-1:0] m_pwdata = '0, m_rsp_data = '0;
  int            exp_pick;
  assign exp_pick = pick(m_last, req_valid);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_dec <= 0; m_age <= 0; m_req <= 0; m_last <= NREQ - 1;
      m_paddr <= '0; m_prwd <= 0; m_pwdata <= '0; m_slave <= 0;
      m_rsp <= 0; m_rsp_req <= 0; m_rsp_err <= 0; m_rsp_data <= '0;
    end else if (m_busy) begin
      m_rsp <= 0;
      if (m_dec) m_busy <= 0;
      else if (m_age >= 2 && pready) begin
        m_busy <= 0; m_rsp <= 1; m_rsp_req <= m_req;
        m_rsp_err <= pslverr; m_rsp_data <= m_prwd ? '0 : prdata;
      end else if (TO_ON && m_age >= 2 && (m_age - 1) == TO) begin
        m_busy <= 0; m_rsp <= 1; m_rsp_req <= m_req; m_rsp_err <= 1; m_rsp_data <= '0;
      end else m_age <= m_age + 1;
    end else if (exp_pick >= 0) begin
      m_busy <= 1; m_age <= 1; m_req <= exp_pick; m_last <= exp_pick;
      m_paddr  <= req_addr[exp_pick*AW +: AW];
      m_prwd   <= req_write[exp_pick];
      m_pwdata <= req_write[exp_pick] ? req_wdata[exp_pick*DW +: DW] : '0;
      m_slave  <= int'(req_addr[exp_pick*AW+12 +: 4]);
      m_dec    <= int'(req_addr[exp_pick*AW+12 +: 4]) >= NSL;
      m_rsp    <= int'(req_addr[exp_pick*AW+12 +: 4]) >= NSL;
      m_rsp_req <= exp_pick; m_rsp_err <= 1; m_rsp_data <= '0;
    end else m_rsp <= 0;
  end

  initial forever begin
    @(negedge clk);
    chk("req_ready", req_ready, (!m_busy && rst_n && exp_pick >= 0) ? NREQ'(1 << exp_pick) : '0);
    chk("psel",    psel,    (m_busy && !m_dec) ? 16'(1 << m_slave) : 16'h0);
    chk("penable", penable, m_busy && !m_dec && m_age >= 2);
    chk("paddr",   paddr,   m_paddr);
    chk("prwd",    prwd,    m_prwd);
    chk("pwdata",  pwdata,  m_pwdata);
    chk("rsp_valid", rsp_valid, m_rsp ? NREQ'(1 << m_rsp_req) : '0);
    if (m_rsp) begin
      chk("rsp_rdata", rsp_rdata, m_rsp_data);
      chk("rsp_err",   rsp_err,   m_rsp_err);
    end
  end

  // Event logs for the directed checks.
  int gq_idx[$], gq_cyc[$], rq_req[$], rq_cyc[$], rq_err[$];
  logic [DW-1:0] rq_data[$];
  int pen_cnt = 0, psel_cnt = 0, psel_start = 0, pen_start = 0;
  logic [15:0] psel_last = '0;
  bit psel_prev = 0, pen_prev = 0;
  always @(negedge clk) begin
    if (req_ready != 0) begin gq_idx.push_back(oh2i(req_ready)); gq_cyc.push_back(cyc); end
    if (rsp_valid != 0) begin
      rq_req.push_back(oh2i(rsp_valid)); rq_cyc.push_back(cyc);
      rq_err.push_back(int'(rsp_err));   rq_data.push_back(rsp_rdata);
    end
    if (psel != 0) begin
      psel_last <= psel; psel_cnt <= psel_cnt + 1;
      if (!psel_prev) psel_start <= cyc;
    end
    if (penable) begin
      pen_cnt <= pen_cnt + 1;
      if (!pen_prev) pen_start <= cyc;
    end
    psel_prev <= (psel != 0);
    pen_prev  <= penable;
  end

  task automatic nxt();
    @(posedge clk); #2;
  endtask

  task automatic set_payload(input int i, input logic [AW-1:0] a, input bit w, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_write[i]          = w;
  endtask

  task automatic wait_grant(input int base, output int g, output int gc);
    g = -1; gc = 0;
    for (int k = 0; k < 60; k++) begin
      if (gq_idx.size() > base) break;
      nxt();
    end
    chk("grant_seen", gq_idx.size() > base, 1);
    if (gq_idx.size() > base) begin g = gq_idx[base]; gc = gq_cyc[base]; end
  endtask

  task automatic issue(input int i, input logic [AW-1:0] a, input bit w, input logic [DW-1:0] d,
                       output int g, output int gc);
    int base;
    base = gq_idx.size();
    set_payload(i, a, w, d);
    req_valid[i] = 1'b1;
    wait_grant(base, g, gc);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int base, input int n);
    for (int k = 0; k < 60; k++) begin
      if (rq_req.size() >= base + n) break;
      nxt();
    end
    chk("rsp_seen", rq_req.size() >= base + n, 1);
  endtask

  task automatic reset_check();
    rst_n = 1'b0;
    #1;
    chk("rst_psel", psel, 16'h0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    nxt(); nxt();
  endtask

  int g, gc, g2, gc2, br, bg, p0, pc0;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    #1 rst_n = 1'b0;
    nxt(); nxt();
    rst_n = 1'b1;
    nxt();

    // Single read to slave 3
    prdata = 32'hDEAD_BEEF; br = rq_req.size(); p0 = pen_cnt;
    issue(0, 32'h0000_3004, 1'b0, 32'h0, g, gc);
    chk("t1_grant", g, 0);
    wait_rsp(br, 1);
    if (rq_req.size() > br) begin
      chk("t1_latency", rq_cyc[br] - gc, 3);
      chk("t1_rsp_req", rq_req[br], 0);
      chk("t1_rdata", rq_data[br], 32'hDEAD_BEEF);
      chk("t1_err", rq_err[br], 0);
    end
    chk("t1_psel", psel_last, 16'h0008);
    chk("t1_setup_cycle", psel_start - gc, 1);
    chk("t1_access_cycle", pen_start - gc, 2);
    chk("t1_pen_cycles", pen_cnt - p0, 1);

    // Back to reset state, then all four requesters contend with writes
    reset_check();
    chk("rst_paddr", paddr, 32'h0);
    rst_n = 1'b1;
    nxt();
    for (int i = 0; i < NREQ; i++) set_payload(i, 32'h0000_1010 + ((i + 1) << 12), 1'b1, 32'hA5A5_0000 + i);
    bg = gq_idx.size(); br = rq_req.size();
    req_valid = '1;
    for (int k = 0; k < 40; k++) begin
      if (gq_idx.size() >= bg + 5) break;
      nxt();
    end
    req_valid = '0;
    chk("t2_grants", gq_idx.size() >= bg + 5, 1);
    if (gq_idx.size() >= bg + 5) begin
      for (int j = 0; j < 5; j++) chk("t2_order", gq_idx[bg + j], exp_order[j]);
      for (int j = 0; j < 4; j++) chk("t2_spacing", gq_cyc[bg + j + 1] - gq_cyc[bg + j], 3);
    end
    wait_rsp(br, 5);
    if (rq_req.size() >= br + 5)
      for (int j = 0; j < 5; j++) chk("t2_rsp_err", rq_err[br + j], 0);

    // Write to slave 5 with three wait states and a slave error
    nxt(); nxt();
    wait_states = 3; slv_err = 1'b1; br = rq_req.size(); p0 = pen_cnt;
    issue(1, 32'h0000_5008, 1'b1, 32'h1234_5678, g, gc);
    wait_rsp(br, 1);
    chk("t3_pen_cycles", pen_cnt - p0, 4);
    chk("t3_psel", psel_last, 16'h0020);
    if (rq_req.size() > br) begin
      chk("t3_latency", rq_cyc[br] - gc, 6);
      chk("t3_err", rq_err[br], 1);
      chk("t3_rdata", rq_data[br], 32'h0);
    end
    wait_states = 0; slv_err = 1'b0;

    // Address decodes to slave 10, beyond the 8 implemented
    nxt(); nxt();
    prdata = 32'h5555_AAAA; br = rq_req.size(); p0 = pen_cnt; pc0 = psel_cnt;
    issue(2, 32'h0000_A000, 1'b0, 32'h0, g, gc);
    wait_rsp(br, 1);
    if (rq_req.size() > br) begin
      chk("t4_latency", rq_cyc[br] - gc, 1);
      chk("t4_err", rq_err[br], 1);
      chk("t4_rdata", rq_data[br], 32'h0);
      chk("t4_rsp_req", rq_req[br], 2);
    end
    nxt(); nxt();
    chk("t4_no_psel", psel_cnt - pc0, 0);
    chk("t4_no_penable", pen_cnt - p0, 0);

    // Slave never answers
    stuck = 1'b1; br = rq_req.size(); p0 = pen_cnt;
    issue(1, 32'h0000_2000, 1'b0, 32'h0, g, gc);
`ifdef APB_ARB_MASTER_TIMEOUT_EN
    wait_rsp(br, 1);
    chk("t6_pen_cycles", pen_cnt - p0, 16);
    if (rq_req.size() > br) begin
      chk("t6_latency", rq_cyc[br] - gc, 18);
      chk("t6_err", rq_err[br], 1);
      chk("t6_rdata", rq_data[br], 32'h0);
    end
`else
    repeat (1000) nxt();
    chk("t6_still_access", penable, 1);
    chk("t6_psel", psel, 16'h0004);
    chk("t6_no_rsp", rq_req.size() - br, 0);
    chk("t6_pen_cycles", pen_cnt - p0 >= 990, 1);
`endif

    // Reset in the middle of an ACCESS phase
    if (!penable) begin
      issue(0, 32'h0000_1000, 1'b0, 32'h0, g, gc);
      for (int k = 0; k < 10; k++) begin
        if (penable) break;
        nxt();
      end
    end
    chk("t5_in_access", penable, 1);
    br = rq_req.size();
    reset_check();
    stuck = 1'b0;
    rst_n = 1'b1;
    repeat (3) nxt();
    chk("t5_no_rsp", rq_req.size() - br, 0);
    set_payload(3, 32'h0000_3000, 1'b0, 32'h0);
    set_payload(0, 32'h0000_1000, 1'b1, 32'hCAFE_0001);
    bg = gq_idx.size();
    req_valid = 4'b1001;
    wait_grant(bg, g, gc);
    if (g >= 0) req_valid[g] = 1'b0;
    chk("t5_first_grant", g, 0);
    wait_grant(bg + 1, g2, gc2);
    if (g2 >= 0) req_valid[g2] = 1'b0;
    chk("t5_second_grant", g2, 3);
    req_valid = '0;
    wait_rsp(br, 2);
    nxt(); nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
